// File: rtl/testmasterslave7_feeder.sv
// Upstream feeder for the TestMasterSlave7 slave input. Buffers words from a blocking
// sync/notify producer and emits one word per PERIOD cycles as a one-cycle strobe.
module testmasterslave7_feeder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PERIOD      = 3,
  parameter int unsigned START_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [31:0]         b_in,
  input  logic                       b_in_sync,
  output logic                       b_in_notify,
  output logic signed [31:0]         m_out,
  output logic                       m_out_sync,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int unsigned DW = 32;
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(PERIOD - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_START = FW'(START_LEVEL);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  typedef enum logic {
    SECTION_PRIME = 1'b0,
    SECTION_RUN   = 1'b1
  } section_t;

  section_t             section;
  logic [TW-1:0]        tick;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic signed [DW-1:0] mem [DEPTH];

  logic                 push_c;
  logic                 pop_c;
  logic [FW-1:0]        fill_next_c;

  // Notify is gated by reset so the producer never sees a slot while held in reset.
  assign b_in_notify = rst && (fill < FILL_FULL);

  always_comb begin
    push_c      = b_in_sync && b_in_notify;
    pop_c       = (section == SECTION_RUN) && (tick == TICK_LAST) && (fill != '0);
    fill_next_c = fill;
    if (push_c && !pop_c) begin
      fill_next_c = fill + FW'(1);
    end else if (pop_c && !push_c) begin
      fill_next_c = fill - FW'(1);
    end
  end

  // Storage needs no reset: only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[tail] <= b_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section    <= SECTION_PRIME;
      tick       <= '0;
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      m_out      <= '0;
      m_out_sync <= 1'b0;
    end else begin
      fill <= fill_next_c;

      if (push_c) begin
        tail <= (tail == PTR_LAST) ? '0 : tail + PW'(1);
      end

      if (pop_c) begin
        head       <= (head == PTR_LAST) ? '0 : head + PW'(1);
        m_out      <= mem[head];
        m_out_sync <= 1'b1;
      end else begin
        m_out_sync <= 1'b0;
      end

      case (section)
        SECTION_PRIME: begin
          tick <= '0;
          if (fill_next_c >= FILL_START) begin
            section <= SECTION_RUN;
          end
        end
        SECTION_RUN: begin
          tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
          // Draining the last word with nothing arriving means re-priming.
          if (pop_c && !push_c && (fill == FW'(1))) begin
            section <= SECTION_PRIME;
            tick    <= '0;
          end
        end
      endcase
    end
  end

endmodule
